// File: rtl/axis_unpack_pkg.sv
// Shared definitions for the AXI-Stream width-down unpacker: drain state
// names and the clogb2 helper used to size lane indices.
package axis_unpack_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } unpack_state_t;

    // Bits needed to hold 'value'; never returns less than one bit.
    function automatic int clogb2(input int value);
        int bits;
        bits = 1;
        for (int v = value >> 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/axis_unpack_lane_sel.sv
// Priority encoder picking the next byte lane to emit from a keep/remaining mask,
// in either MSB-first or LSB-first order.
module axis_unpack_lane_sel
    import axis_unpack_pkg::*;
#(
    parameter int BYTES     = 4,
    parameter int LANE_W    = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [BYTES-1:0]  i_mask,
    output logic [LANE_W-1:0] o_lane,
    output logic [BYTES-1:0]  o_onehot,
    output logic              o_hasOne
);

    // Ascending scan: MSB-first lets later hits overwrite, LSB-first keeps the first hit.
    always_comb begin
        o_lane   = '0;
        o_onehot = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i_mask[i] && (MSB_FIRST || (o_onehot == '0))) begin
                o_lane      = i[LANE_W-1:0];
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

    assign o_hasOne = (i_mask != '0) && ((i_mask & (i_mask - BYTES'(1))) == '0);

endmodule

// File: rtl/axis_unpack.sv
// Width-down AXI-Stream converter: splits DATA_WIDTH beats into single kept bytes,
// skipping null lanes, with registered outputs and a one-beat hold register.
module axis_unpack
    import axis_unpack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [7:0]              m_tdata,
    output logic                    m_tlast,
    output logic                    err_null_last
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = clogb2(BYTES - 1);

    generate
        if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_badWidth
            $fatal(1, "axis_unpack: DATA_WIDTH %0d is not one of 8, 16, 32", DATA_WIDTH);
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_holdData, w_nextData, w_srcData;
    logic [BYTES-1:0]      r_rem, w_nextRem, w_mask, w_onehot;
    logic                  r_holdLast, w_nextLast;
    logic [7:0]            r_mData, w_nextMData, w_byte;
    logic                  r_mValid, w_nextValid;
    logic                  r_mLast, w_nextMLast;
    logic                  r_err, w_nextErr;
    logic                  w_adv, w_accept, w_hasOne;
    logic [LANE_W-1:0]     w_lane;
    unpack_state_t         w_state;

    assign w_state  = (r_rem == '0) ? ST_EMPTY : ST_DRAIN;
    assign w_adv    = !r_mValid || m_tready;
    assign s_tready = !reset && (w_state == ST_EMPTY) && w_adv;
    assign w_accept = s_tvalid && s_tready;

    // An empty hold register selects straight from the incoming beat.
    assign w_mask    = (w_state == ST_EMPTY) ? s_tkeep : r_rem;
    assign w_srcData = (w_state == ST_EMPTY) ? s_tdata : r_holdData;
    assign w_byte    = w_srcData[{w_lane, 3'b000} +: 8];

    axis_unpack_lane_sel #(
        .BYTES     (BYTES),
        .LANE_W    (LANE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_laneSel (
        .i_mask   (w_mask),
        .o_lane   (w_lane),
        .o_onehot (w_onehot),
        .o_hasOne (w_hasOne)
    );

    always_comb begin
        w_nextData  = r_holdData;
        w_nextRem   = r_rem;
        w_nextLast  = r_holdLast;
        w_nextMData = r_mData;
        w_nextValid = r_mValid;
        w_nextMLast = r_mLast;
        w_nextErr   = 1'b0;
        if (w_adv) begin
            case (w_state)
                ST_EMPTY: begin
                    w_nextValid = 1'b0;
                    if (w_accept) begin
                        if (s_tkeep != '0) begin
                            w_nextMData = w_byte;
                            w_nextValid = 1'b1;
                            w_nextMLast = s_tlast && w_hasOne;
                            w_nextData  = s_tdata;
                            w_nextRem   = s_tkeep & ~w_onehot;
                            w_nextLast  = s_tlast;
                        end else begin
                            // A keep-less beat cannot carry tlast downstream; flag and drop it.
                            w_nextErr = s_tlast;
                        end
                    end
                end
                ST_DRAIN: begin
                    w_nextMData = w_byte;
                    w_nextValid = 1'b1;
                    w_nextMLast = r_holdLast && w_hasOne;
                    w_nextRem   = r_rem & ~w_onehot;
                end
                default: begin
                    w_nextValid = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_holdData <= '0;
            r_rem      <= '0;
            r_holdLast <= 1'b0;
            r_mData    <= '0;
            r_mValid   <= 1'b0;
            r_mLast    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_holdData <= w_nextData;
            r_rem      <= w_nextRem;
            r_holdLast <= w_nextLast;
            r_mData    <= w_nextMData;
            r_mValid   <= w_nextValid;
            r_mLast    <= w_nextMLast;
            r_err      <= w_nextErr;
        end
    end

    assign m_tvalid      = r_mValid;
    assign m_tdata       = r_mData;
    assign m_tlast       = r_mLast;
    assign err_null_last = r_err;

endmodule

// File: tb/tb_axis_unpack.sv
// Bench for axis_unpack: MSB-first and LSB-first instances share one input stream,
// each checked against a byte-queue model fed from a vector table or random beats.
module tb_axis_unpack;

    logic        clk = 1'b0;
    logic        reset;
    logic        sValid;
    logic [31:0] sData;
    logic [3:0]  sKeep;
    logic        sLast;
    logic        mReady;

    logic        sReadyA, mValidA, mLastA, errA;
    logic [7:0]  mDataA;
    logic        sReadyB, mValidB, mLastB, errB;
    logic [7:0]  mDataB;

    always #5 clk = ~clk;

    axis_unpack #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .reset(reset),
        .s_tvalid(sValid), .s_tready(sReadyA), .s_tdata(sData), .s_tkeep(sKeep), .s_tlast(sLast),
        .m_tvalid(mValidA), .m_tready(mReady), .m_tdata(mDataA), .m_tlast(mLastA),
        .err_null_last(errA)
    );

    axis_unpack #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .reset(reset),
        .s_tvalid(sValid), .s_tready(sReadyB), .s_tdata(sData), .s_tkeep(sKeep), .s_tlast(sLast),
        .m_tvalid(mValidB), .m_tready(mReady), .m_tdata(mDataB), .m_tlast(mLastB),
        .err_null_last(errB)
    );

    // expMsb/expLsb hold the emitted bytes in order, first byte in bits [7:0].
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          nExp;
        logic [31:0] expMsb;
        logic [31:0] expLsb;
    } vec_t;

    vec_t        vectors [8];
    int          nVectors = 0;
    int          nMiscompares = 0;
    logic [8:0]  qMsb [$];
    logic [8:0]  qLsb [$];
    logic        expErrA = 1'b0, expErrB = 1'b0;
    logic        heldA = 1'b0, heldB = 1'b0;
    logic [8:0]  heldValA = '0, heldValB = '0;
    logic        acceptedA = 1'b0;
    logic        randReady = 1'b0;
    int          runLen = 0, maxRun = 0;
    logic [31:0] curOrderMsb, curOrderLsb;
    int          curN;
    logic        curLast;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the lanes in emit order and collect kept bytes.
    function automatic logic [31:0] modelOrder(input logic [31:0] data, input logic [3:0] keep,
                                               input bit msbFirst);
        logic [31:0] result;
        int n;
        result = '0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            int lane;
            lane = msbFirst ? 3 - k : k;
            if (keep[lane]) begin
                result[8*n +: 8] = data[8*lane +: 8];
                n++;
            end
        end
        return result;
    endfunction

    task automatic scoreDut(input bit isMsb, input logic sReadyX, input logic mValidX,
                            input logic [7:0] mDataX, input logic mLastX, input logic errX);
        logic [8:0]  got;
        logic [8:0]  want;
        logic [31:0] order;
        string       tag;
        got = {mLastX, mDataX};
        tag = isMsb ? "msb" : "lsb";
        checkVal({tag, " err_null_last"}, errX, isMsb ? expErrA : expErrB);
        if (isMsb ? heldA : heldB) begin
            checkVal({tag, " held valid"}, mValidX, 1);
            checkVal({tag, " held last/byte"}, got, isMsb ? heldValA : heldValB);
        end
        if (reset) begin
            if (isMsb) begin qMsb.delete(); expErrA = 1'b0; heldA = 1'b0; end
            else       begin qLsb.delete(); expErrB = 1'b0; heldB = 1'b0; end
            return;
        end
        if (mValidX && mReady) begin
            if ((isMsb ? qMsb.size() : qLsb.size()) == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL %s spurious byte: got 0x%0h, expected no output at %0t", tag, got, $time);
            end else begin
                if (isMsb) want = qMsb.pop_front();
                else       want = qLsb.pop_front();
                checkVal({tag, " last/byte"}, got, want);
            end
        end
        if (isMsb) begin heldA = mValidX && !mReady; heldValA = got; end
        else       begin heldB = mValidX && !mReady; heldValB = got; end
        if (isMsb) expErrA = 1'b0; else expErrB = 1'b0;
        if (sValid && sReadyX) begin
            order = isMsb ? curOrderMsb : curOrderLsb;
            for (int j = 0; j < curN; j++) begin
                if (isMsb) qMsb.push_back({curLast && (j == curN - 1), order[8*j +: 8]});
                else       qLsb.push_back({curLast && (j == curN - 1), order[8*j +: 8]});
            end
            if (isMsb) begin expErrA = (sKeep == 4'h0) && sLast; acceptedA = 1'b1; end
            else       expErrB = (sKeep == 4'h0) && sLast;
        end
    endtask

    task automatic checkOutput();
        #1;
        acceptedA = 1'b0;
        scoreDut(1'b1, sReadyA, mValidA, mDataA, mLastA, errA);
        scoreDut(1'b0, sReadyB, mValidB, mDataB, mLastB, errB);
        if (mValidA && mReady && !reset) runLen++;
        else runLen = 0;
        if (runLen > maxRun) maxRun = runLen;
        @(negedge clk);
    endtask

    task automatic cycle();
        if (randReady) mReady = ($urandom_range(0, 3) != 0);
        checkOutput();
    endtask

    task automatic idle(input int n);
        sValid = 1'b0;
        for (int t = 0; t < n; t++) cycle();
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep, input logic last,
                                 input logic [31:0] expM, input logic [31:0] expL, input int n);
        sValid      = 1'b1;
        sData       = data;
        sKeep       = keep;
        sLast       = last;
        curOrderMsb = expM;
        curOrderLsb = expL;
        curN        = n;
        curLast     = last;
        for (int t = 0; t < 40; t++) begin
            cycle();
            if (acceptedA) return;
        end
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL accept timeout: s_tready stayed 0, expected accept within 40 cycles");
        sValid = 1'b0;
    endtask

    task automatic applyModel(input logic [31:0] data, input logic [3:0] keep, input logic last);
        applyStimulus(data, keep, last, modelOrder(data, keep, 1'b1), modelOrder(data, keep, 1'b0),
                      $countones(keep));
    endtask

    task automatic expectReady(input logic exp, input string name);
        #1;
        checkVal(name, sReadyA, exp);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0] = '{32'h33323130, 4'hF,    1'b1, 4, 32'h30313233, 32'h33323130};
        vectors[1] = '{32'h2F2E2D2C, 4'b1010, 1'b0, 2, 32'h00002D2F, 32'h00002F2D};
        vectors[2] = '{32'h00323130, 4'b0111, 1'b1, 3, 32'h00303132, 32'h00323130};
        vectors[3] = '{32'hDEADBEEF, 4'h0,    1'b1, 0, 32'h0,        32'h0};
        vectors[4] = '{32'hA5A5A5A5, 4'h0,    1'b0, 0, 32'h0,        32'h0};
        vectors[5] = '{32'h44434241, 4'b1001, 1'b1, 2, 32'h00004144, 32'h00004441};
        vectors[6] = '{32'h11223344, 4'b0100, 1'b0, 1, 32'h00000022, 32'h00000022};
        vectors[7] = '{32'h55667788, 4'b0001, 1'b1, 1, 32'h00000088, 32'h00000088};

        reset  = 1'b1;
        sValid = 1'b0;
        sData  = '0;
        sKeep  = '0;
        sLast  = 1'b0;
        mReady = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("reset m_tvalid", mValidA, 0);
        checkVal("reset m_tdata", mDataA, 0);
        checkVal("reset m_tlast", mLastA, 0);
        checkVal("reset err_null_last", errA, 0);
        checkVal("reset s_tready", sReadyA, 0);
        checkVal("reset lsb m_tvalid", mValidB, 0);
        reset = 1'b0;

        $display("[TB] table vectors");
        mReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].data, vectors[i].keep, vectors[i].last,
                          vectors[i].expMsb, vectors[i].expLsb, vectors[i].nExp);
        end
        idle(6);
        checkVal("table drained msb", qMsb.size(), 0);
        checkVal("table drained lsb", qLsb.size(), 0);

        $display("[TB] full keep s_tready occupancy");
        applyModel(32'h33323130, 4'hF, 1'b1);
        sValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expectReady(k == 3, "full keep s_tready");
            checkOutput();
        end
        idle(2);

        $display("[TB] backpressure pattern");
        begin
            logic readyPat [7];
            readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            applyModel(32'hC3C2C1C0, 4'hF, 1'b1);
            sValid = 1'b0;
            for (int k = 0; k < 7; k++) begin
                mReady = readyPat[k];
                checkOutput();
            end
            mReady = 1'b1;
            checkVal("backpressure all bytes out", qMsb.size(), 0);
            idle(3);
        end

        $display("[TB] back-to-back beats");
        runLen = 0;
        maxRun = 0;
        applyModel(32'h03020100, 4'hF, 1'b0);
        applyModel(32'h07060504, 4'hF, 1'b0);
        applyModel(32'h0B0A0908, 4'hF, 1'b1);
        idle(6);
        checkVal("back-to-back consecutive bytes", maxRun, 12);

        $display("[TB] reset mid-beat");
        applyModel(32'h77665544, 4'hF, 1'b1);
        sValid = 1'b0;
        checkOutput();
        checkOutput();
        reset = 1'b1;
        checkOutput();
        reset = 1'b0;
        #1;
        checkVal("post-reset m_tvalid", mValidA, 0);
        checkVal("post-reset lsb m_tvalid", mValidB, 0);
        checkVal("post-reset s_tready", sReadyA, 1);
        checkOutput();
        idle(4);

        $display("[TB] random beats");
        randReady = 1'b1;
        for (int b = 0; b < 250; b++) begin
            applyModel($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        randReady = 1'b0;
        mReady = 1'b1;
        idle(10);
        checkVal("random drained msb", qMsb.size(), 0);
        checkVal("random drained lsb", qLsb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
